fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the combinational byte-addressed instruction memory.

---
 rtl/fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_ctrl : PC owner and fetch sequencer with a 2-entry decode queue.   |
// | Optional FETCH_PERF_CNT_EN adds stall_cycles / fetch_count counters.     |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module fetch_ctrl #(
  parameter int                W        = 32,
  parameter int                PC_LEN   = 32,
  parameter int                D        = 128,
  parameter logic [PC_LEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_LEN-1:0] imem_addr,
  input  logic [W-1:0]      imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_LEN-1:0] redirect_pc,
  input  logic              halt,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [W-1:0]      fetch_instr,
  output logic [PC_LEN-1:0] fetch_pc,
  output logic              fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       fetch_count
`endif
);

  localparam logic [PC_LEN-1:0] C_LAST_PC = PC_LEN'(D - 4);
  localparam logic [PC_LEN-1:0] C_PC_STEP = PC_LEN'(4);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_LEN-1:0] r_pc;
  logic              r_fault;
  logic [1:0]        r_count;
  logic              r_head;
  logic [W-1:0]      r_q_instr [2];
  logic [PC_LEN-1:0] r_q_pc    [2];

  logic w_pop;
  logic w_push;
  logic w_set_fault;
  logic w_fault_cond;
  logic w_tail;

  assign imem_addr    = r_pc;
  assign fault        = r_fault;
  assign fetch_valid  = (r_count != 2'd0);
  assign fetch_instr  = fetch_valid ? r_q_instr[r_head] : '0;
  assign fetch_pc     = fetch_valid ? r_q_pc[r_head]    : '0;
  assign w_pop        = fetch_valid & fetch_ready;
  assign w_fault_cond = (r_pc[1:0] != 2'b00) || (r_pc > C_LAST_PC);
  // Tail is head+count mod 2; with count=2 it aliases the slot being popped.
  assign w_tail       = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_set_fault = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = halt ? ST_HALT : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt) begin
            w_state_nxt = ST_HALT;
          end else if (w_fault_cond) begin
            w_state_nxt = ST_FAULT;
            w_set_fault = 1'b1;
          end else if ((r_count != 2'd2) || w_pop) begin
            w_push = 1'b1;
          end
        end
        ST_HALT: begin
          if (!halt) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else if (redirect_valid) begin
      // Flush wins over any handshake in flight this cycle.
      r_pc    <= redirect_pc;
      r_fault <= 1'b0;
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_instr[w_tail] <= imem_rdata;
        r_q_pc[w_tail]    <= r_pc;
        r_pc              <= r_pc + C_PC_STEP;
      end
      if (w_set_fault) begin
        r_fault <= 1'b1;
      end
      r_head <= r_head ^ w_pop;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_fetch_count  <= 32'd0;
    end else begin
      if (fetch_valid && !fetch_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_push) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign fetch_count  = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_ctrl : directed scoreboard bench for fetch_ctrl.                |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] fetch_count;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wmem [0:31];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .W(32), .PC_LEN(32), .D(128), .RESET_PC(32'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fault          (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .fetch_count    (fetch_count)
`endif
  );

  initial begin
    for (int i = 0; i < 32; i++) wmem[i] = 32'h1000_0000 | (i * 4);
    wmem[0] = 32'h0000_0013;
    wmem[1] = 32'h0010_0093;
  end

  always_comb begin
    imem_rdata = 32'hDEAD_BEEF;
    if (imem_addr < 32'd128) imem_rdata = wmem[imem_addr[6:2]];
  end

  function automatic exp_t ent(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = (pc == 32'd0) ? 32'h0000_0013 :
              (pc == 32'd4) ? 32'h0010_0093 : (32'h1000_0000 | pc);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb.push_back(ent(pc));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a head accepted at the coming edge is compared mid-cycle.
  always @(negedge clk) begin
    if (rst_n && fetch_valid && fetch_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h expected none", fetch_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("deliver_pc", fetch_pc, mon_e.pc);
        chk("deliver_instr", fetch_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    tick; tick;
    chk("reset_valid", {31'd0, fetch_valid}, 32'd0);
    chk("reset_instr", fetch_instr, 32'd0);
    chk("reset_pc", fetch_pc, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    chk("reset_addr", imem_addr, 32'd0);

    // Streaming with ready held high
    expect_pc(32'd0); expect_pc(32'd4); expect_pc(32'd8);
    rst_n = 1'b1; fetch_ready = 1'b1;
    tick;
    chk("t1_first_valid", {31'd0, fetch_valid}, 32'd1);
    chk("t1_pc0", fetch_pc, 32'd0);
    chk("t1_instr0", fetch_instr, 32'h0000_0013);
    tick; chk("t1_pc4", fetch_pc, 32'd4);
    chk("t1_instr4", fetch_instr, 32'h0010_0093);
    tick; chk("t1_pc8", fetch_pc, 32'd8);
    tick; chk("t1_pc12", fetch_pc, 32'd12);
    fetch_ready = 1'b0; rst_n = 1'b0;
    tick;
    chk("t1_drained", sb.size(), 32'd0);
    chk("t1_reset_valid", {31'd0, fetch_valid}, 32'd0);

    // Backpressure fills the queue, then drains with no gap
    expect_pc(32'd0); expect_pc(32'd4); expect_pc(32'd8);
    rst_n = 1'b1;
    repeat (5) tick;
    chk("t2_addr_hold", imem_addr, 32'd8);
    chk("t2_head_pc", fetch_pc, 32'd0);
    chk("t2_valid", {31'd0, fetch_valid}, 32'd1);
    fetch_ready = 1'b1;
    tick; chk("t2_pc4", fetch_pc, 32'd4);
    tick; chk("t2_pc8", fetch_pc, 32'd8);
    tick; chk("t2_full_head", fetch_pc, 32'd12);

    // Redirect flushes a full queue
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick;
    chk("t3_flush_valid", {31'd0, fetch_valid}, 32'd0);
    chk("t3_addr", imem_addr, 32'h20);
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    expect_pc(32'h20); expect_pc(32'h24);
    tick; chk("t3_pc20", fetch_pc, 32'h20);
    tick; tick;

    // Run off the end of memory into a fault
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h78;
    tick;
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    expect_pc(32'h78); expect_pc(32'h7C);
    tick; chk("t4_pc78", fetch_pc, 32'h78);
    tick; chk("t4_pc7c", fetch_pc, 32'h7C);
    chk("t4_addr80", imem_addr, 32'h80);
    tick;
    chk("t4_fault", {31'd0, fault}, 32'd1);
    chk("t4_no_valid", {31'd0, fetch_valid}, 32'd0);
    tick; tick;
    chk("t4_fault_hold", {31'd0, fault}, 32'd1);
    chk("t4_still_empty", {31'd0, fetch_valid}, 32'd0);
    chk("t4_addr_hold", imem_addr, 32'h80);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick;
    chk("t4_fault_clr", {31'd0, fault}, 32'd0);
    redirect_valid = 1'b0;
    expect_pc(32'd0); expect_pc(32'd4);
    tick; chk("t4_resume_pc0", fetch_pc, 32'd0);
    tick; chk("t4_resume_pc4", fetch_pc, 32'd4);

    // Halt drains the queue and freezes the PC
    halt = 1'b1;
    tick; chk("t5_addr_a", imem_addr, 32'd8);
    tick; chk("t5_addr_b", imem_addr, 32'd8);
    tick; chk("t5_addr_c", imem_addr, 32'd8);
    chk("t5_drained", {31'd0, fetch_valid}, 32'd0);
    halt = 1'b0;
    expect_pc(32'd8);
    tick; chk("t5_restart_bubble", {31'd0, fetch_valid}, 32'd0);
    tick; chk("t5_resume_pc", fetch_pc, 32'd8);
    tick;

    // Misaligned redirect target faults; reset clears it
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    tick;
    redirect_valid = 1'b0;
    chk("t6_flush_valid", {31'd0, fetch_valid}, 32'd0);
    chk("t6_addr", imem_addr, 32'h6);
    tick;
    chk("t6_fault", {31'd0, fault}, 32'd1);
    chk("t6_no_valid", {31'd0, fetch_valid}, 32'd0);
    tick;
    chk("t6_no_valid_b", {31'd0, fetch_valid}, 32'd0);
    rst_n = 1'b0;
    tick;
    chk("t6_rst_addr", imem_addr, 32'd0);
    chk("t6_rst_fault", {31'd0, fault}, 32'd0);
    chk("t6_rst_valid", {31'd0, fetch_valid}, 32'd0);
    rst_n = 1'b1;
    expect_pc(32'd0);
    tick; chk("t6_after_rst_pc", fetch_pc, 32'd0);
    fetch_ready = 1'b1;
    tick;
    fetch_ready = 1'b0;
    tick;
    chk("final_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
